// File: rtl/core_savestate_ctrl.sv
// core_savestate_ctrl: copies a savestate image between the emulated core's
// state port and the bridge-visible buffer, one word at a time, with the core
// paused for the duration of the copy.
module core_savestate_ctrl #(
    parameter int  WORDS   = 4096,
    parameter int  TIMEOUT = 65535,
    localparam int AW      = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          savestate_start,
    input  logic          savestate_load,
    output logic          savestate_start_ack,
    output logic          savestate_start_busy,
    output logic          savestate_start_ok,
    output logic          savestate_start_err,
    output logic          savestate_load_ack,
    output logic          savestate_load_busy,
    output logic          savestate_load_ok,
    output logic          savestate_load_err,
    output logic          core_pause_req,
    input  logic          core_paused,
    output logic [AW-1:0] cs_addr,
    output logic          cs_rd,
    output logic          cs_wr,
    output logic [31:0]   cs_wdata,
    input  logic [31:0]   cs_rdata,
    input  logic          cs_ack,
    output logic [AW-1:0] buf_addr,
    output logic          buf_rd,
    output logic          buf_wr,
    output logic [31:0]   buf_wdata,
    input  logic [31:0]   buf_rdata,
    input  logic          buf_ack
);

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        PAUSE,
        RD,
        WR,
        UNPAUSE,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

    state_t        state_q, state_d;
    logic          save_mode_q, save_mode_d;
    logic [AW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          error_q, error_d;
    logic          start_q, load_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          pause_q, pause_d;
    logic          cs_rd_q, cs_rd_d, cs_wr_q, cs_wr_d;
    logic          buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
    logic          start_ack_q, start_ack_d, start_busy_q, start_busy_d;
    logic          start_ok_q, start_ok_d, start_err_q, start_err_d;
    logic          load_ack_q, load_ack_d, load_busy_q, load_busy_d;
    logic          load_ok_q, load_ok_d, load_err_q, load_err_d;

    logic          start_edge, load_edge;
    logic          src_ack, dst_ack, timed_out;
    logic [31:0]   src_rdata;
    logic          issue_rd, issue_wr;

    // Rising edges compare the live request against last cycle's sample.
    assign start_edge = savestate_start & ~start_q;
    assign load_edge  = savestate_load & ~load_q;

    // Source/destination steering: SAVE reads the core and writes the buffer,
    // LOAD does the reverse.
    assign src_ack   = save_mode_q ? cs_ack : buf_ack;
    assign dst_ack   = save_mode_q ? buf_ack : cs_ack;
    assign src_rdata = save_mode_q ? cs_rdata : buf_rdata;
    assign timed_out = (timer_q == TIMER_MAX);

    // Next-state and next-output computation; every output is the registered
    // copy of one of these values.
    always_comb begin
        state_d      = state_q;
        save_mode_d  = save_mode_q;
        count_d      = count_q;
        timer_d      = timer_q;
        error_d      = error_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pause_d      = pause_q;
        cs_rd_d      = 1'b0;
        cs_wr_d      = 1'b0;
        buf_rd_d     = 1'b0;
        buf_wr_d     = 1'b0;
        start_ack_d  = 1'b0;
        load_ack_d   = 1'b0;
        start_busy_d = start_busy_q;
        start_ok_d   = start_ok_q;
        start_err_d  = start_err_q;
        load_busy_d  = load_busy_q;
        load_ok_d    = load_ok_q;
        load_err_d   = load_err_q;
        issue_rd     = 1'b0;
        issue_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    save_mode_d  = 1'b1;
                    start_ack_d  = 1'b1;
                    start_busy_d = 1'b1;
                    start_ok_d   = 1'b0;
                    start_err_d  = 1'b0;
                    error_d      = 1'b0;
                    state_d      = ACK;
                end else if (load_edge) begin
                    save_mode_d = 1'b0;
                    load_ack_d  = 1'b1;
                    load_busy_d = 1'b1;
                    load_ok_d   = 1'b0;
                    load_err_d  = 1'b0;
                    error_d     = 1'b0;
                    state_d     = ACK;
                end
            end
            ACK: begin
                count_d = '0;
                timer_d = '0;
                pause_d = 1'b1;
                state_d = PAUSE;
            end
            PAUSE: begin
                if (core_paused) begin
                    addr_d   = count_q;
                    issue_rd = 1'b1;
                    state_d  = RD;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    pause_d = 1'b0;
                    state_d = UNPAUSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RD: begin
                if (src_ack) begin
                    wdata_d  = src_rdata;
                    addr_d   = count_q;
                    issue_wr = 1'b1;
                    state_d  = WR;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    pause_d = 1'b0;
                    state_d = UNPAUSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WR: begin
                if (dst_ack) begin
                    if (count_q == LAST_WORD) begin
                        pause_d = 1'b0;
                        state_d = UNPAUSE;
                    end else begin
                        count_d  = count_q + 1'b1;
                        addr_d   = count_q + 1'b1;
                        issue_rd = 1'b1;
                        state_d  = RD;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    pause_d = 1'b0;
                    state_d = UNPAUSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            UNPAUSE: begin
                pause_d = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (save_mode_q) begin
                    start_busy_d = 1'b0;
                    start_ok_d   = ~error_q;
                    start_err_d  = error_q;
                end else begin
                    load_busy_d = 1'b0;
                    load_ok_d   = ~error_q;
                    load_err_d  = error_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue_rd) begin
            timer_d = '0;
            if (save_mode_q) begin
                cs_rd_d = 1'b1;
            end else begin
                buf_rd_d = 1'b1;
            end
        end
        if (issue_wr) begin
            timer_d = '0;
            if (save_mode_q) begin
                buf_wr_d = 1'b1;
            end else begin
                cs_wr_d = 1'b1;
            end
        end
    end

    // State, counters, request samples and all outputs; reset aborts any
    // transfer and drops the pause request without reporting a result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            save_mode_q  <= 1'b0;
            count_q      <= '0;
            timer_q      <= '0;
            error_q      <= 1'b0;
            start_q      <= 1'b0;
            load_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pause_q      <= 1'b0;
            cs_rd_q      <= 1'b0;
            cs_wr_q      <= 1'b0;
            buf_rd_q     <= 1'b0;
            buf_wr_q     <= 1'b0;
            start_ack_q  <= 1'b0;
            start_busy_q <= 1'b0;
            start_ok_q   <= 1'b0;
            start_err_q  <= 1'b0;
            load_ack_q   <= 1'b0;
            load_busy_q  <= 1'b0;
            load_ok_q    <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            save_mode_q  <= save_mode_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            error_q      <= error_d;
            start_q      <= savestate_start;
            load_q       <= savestate_load;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pause_q      <= pause_d;
            cs_rd_q      <= cs_rd_d;
            cs_wr_q      <= cs_wr_d;
            buf_rd_q     <= buf_rd_d;
            buf_wr_q     <= buf_wr_d;
            start_ack_q  <= start_ack_d;
            start_busy_q <= start_busy_d;
            start_ok_q   <= start_ok_d;
            start_err_q  <= start_err_d;
            load_ack_q   <= load_ack_d;
            load_busy_q  <= load_busy_d;
            load_ok_q    <= load_ok_d;
            load_err_q   <= load_err_d;
        end
    end

    assign savestate_start_ack  = start_ack_q;
    assign savestate_start_busy = start_busy_q;
    assign savestate_start_ok   = start_ok_q;
    assign savestate_start_err  = start_err_q;
    assign savestate_load_ack   = load_ack_q;
    assign savestate_load_busy  = load_busy_q;
    assign savestate_load_ok    = load_ok_q;
    assign savestate_load_err   = load_err_q;
    assign core_pause_req       = pause_q;
    assign cs_addr              = addr_q;
    assign cs_rd                = cs_rd_q;
    assign cs_wr                = cs_wr_q;
    assign cs_wdata             = wdata_q;
    assign buf_addr             = addr_q;
    assign buf_rd               = buf_rd_q;
    assign buf_wr               = buf_wr_q;
    assign buf_wdata            = wdata_q;

endmodule

// File: doc/core_savestate_ctrl.md
CORE_SAVESTATE_CTRL -- requirements
Module: core_savestate_ctrl

Interface
REQ-001 Parameter WORDS, default 4096: savestate image length in 32-bit words; AW = clog2(WORDS).
REQ-002 Parameter TIMEOUT, default 65535: maximum wait, in clk cycles, for any pause or ack response.
REQ-003 clk  in  1  sole clock; all logic is in this domain.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 savestate_start  in  1  save request from the bridge command handler; the rising edge is significant.
REQ-006 savestate_load  in  1  load request from the bridge command handler; the rising edge is significant.
REQ-007 savestate_start_ack, savestate_start_busy, savestate_start_ok, savestate_start_err  out  1 each  save status to the command handler.
REQ-008 savestate_load_ack, savestate_load_busy, savestate_load_ok, savestate_load_err  out  1 each  load status to the command handler.
REQ-009 core_pause_req  out  1  request that the emulated core freeze; core_paused  in  1  core is frozen.
REQ-010 cs_addr  out  AW, cs_rd  out  1, cs_wr  out  1, cs_wdata  out  32, cs_rdata  in  32, cs_ack  in  1  core state port.
REQ-011 buf_addr  out  AW, buf_rd  out  1, buf_wr  out  1, buf_wdata  out  32, buf_rdata  in  32, buf_ack  in  1  bridge-visible savestate buffer port.

Function
REQ-012 Edge detect: the block SHALL register each request input every cycle; an edge is input=1 while the registered value=0.
REQ-013 States SHALL be IDLE, ACK, PAUSE, RD, WR, UNPAUSE, DONE.
REQ-014 In IDLE, a start edge SHALL select mode SAVE and a load edge SHALL select mode LOAD; the next state is ACK.
REQ-015 If both edges occur in the same cycle, SAVE SHALL win and the load edge SHALL be discarded.
REQ-016 Edges in any state other than IDLE SHALL be discarded and not queued.
REQ-017 On edge acceptance, the block SHALL clear the ok/err pair of the selected mode only; the other mode's flags SHALL be held.
REQ-018 ACK: the selected *_ack SHALL be high for exactly 1 cycle, on the cycle after the edge; *_busy SHALL rise in that same cycle; word counter := 0; next state is PAUSE.
REQ-019 PAUSE: core_pause_req:=1; wait for core_paused=1 and then go to RD.
REQ-020 RD: the block SHALL pulse a 1-cycle read strobe with addr=counter (SAVE: cs_rd; LOAD: buf_rd), then wait for the source ack.
REQ-021 On the source ack cycle, the block SHALL latch the source rdata and go to WR.
REQ-022 WR: the block SHALL pulse a 1-cycle write strobe to the destination (SAVE: buf_wr; LOAD: cs_wr) with addr=counter and wdata=latched word, then wait for the destination ack.
REQ-023 On the destination ack, if counter=WORDS-1 the next state SHALL be UNPAUSE; otherwise counter+1 and the next state is RD.
REQ-024 Exactly one read or write strobe SHALL be outstanding at a time; an ack arriving while no access is outstanding SHALL be ignored.
REQ-025 The timeout counter SHALL reset on entering PAUSE and on each strobe.
REQ-026 If the timeout counter reaches TIMEOUT in any waiting state, the block SHALL set an error flag and go to UNPAUSE.
REQ-027 UNPAUSE: core_pause_req:=0; next state is DONE (no wait on core_paused).
REQ-028 DONE: busy:=0; then either ok:=1 (no error) or err:=1 (error); next state is IDLE.
REQ-029 ok/err SHALL hold until the next accepted edge of the same mode; ok and err SHALL never both be high.
REQ-030 The *_addr and *_wdata outputs SHALL be don't-care when their strobes are low.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While reset_n=0: all outputs 0, state IDLE, counters 0, registered request inputs 0.
REQ-033 Reset asserted mid-operation SHALL abort immediately, releasing core_pause_req, with no ok/err reported.
REQ-034 A request input held high through reset deassertion SHALL produce an edge on the first cycle after reset.

Verification (WORDS=4, TIMEOUT=16)
REQ-035 Save, cs returns 0x11,0x22,0x33,0x44 with 1-cycle acks -> 4 buf_wr at addresses 0..3 with the same data; start_ack is a 1-cycle pulse; start_ok=1; core_pause_req released.
REQ-036 Load, buf returns 0xA0..0xA3 -> cs_wr of 0xA0..0xA3 at addresses 0..3; load_ok=1; start_ok/start_err unchanged.
REQ-037 Same-cycle start and load rising edges -> only start_ack pulses; load flags unchanged; no load run follows.
REQ-038 core_paused held 0 -> start_err=1 about 16 cycles after ack; zero cs/buf strobes issued; core_pause_req=0.
REQ-039 buf_ack withheld on word 2 -> start_err=1; a subsequent start edge clears err and, with normal acks, ends with start_ok=1.
REQ-040 reset_n pulsed low during RD of word 1 -> all outputs 0 immediately; the next start edge performs a full 4-word save.
